// File: rtl/ddr2_wr_arb_pkg.sv
// Shared definitions for the DDR2 write-channel arbiter: geometry-derived
// default widths, FSM state encoding and the round-robin pick helper.
package ddr2_wr_arb_pkg;

   localparam int ROW_BITS = 13;
   localparam int COL_BITS = 10;
   localparam int BA_BITS  = 3;
   localparam int DQ_BITS  = 16;

   localparam int DEF_ADDR_WIDTH = ROW_BITS + COL_BITS + BA_BITS;
   // DDR transfers two DQ words per controller clock
   localparam int DEF_DATA_WIDTH = 2 * DQ_BITS;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_RESP = 2'd3
   } arb_state_e;

   function automatic logic rr_pick(input logic req0, input logic req1, input logic prio);
      if (req0 && req1) begin
         return prio;
      end else if (req1) begin
         return 1'b1;
      end else begin
         return 1'b0;
      end
   endfunction

endpackage

// File: rtl/ddr2_wr_arb.sv
// Two-master round-robin AXI write arbiter in front of the DDR2 controller.
// Optional burst-length checker enabled with `define DDR2_ARB_BEAT_CHK_EN.
module ddr2_wr_arb
   import ddr2_wr_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  init_end,
   input  logic                  m0_awvalid,
   output logic                  m0_awready,
   input  logic [ADDR_WIDTH-1:0] m0_awaddr,
   input  logic [7:0]            m0_awlen,
   input  logic                  m0_wvalid,
   output logic                  m0_wready,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   input  logic                  m0_wlast,
   output logic                  m0_bvalid,
   input  logic                  m0_bready,
   input  logic                  m1_awvalid,
   output logic                  m1_awready,
   input  logic [ADDR_WIDTH-1:0] m1_awaddr,
   input  logic [7:0]            m1_awlen,
   input  logic                  m1_wvalid,
   output logic                  m1_wready,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   input  logic                  m1_wlast,
   output logic                  m1_bvalid,
   input  logic                  m1_bready,
   output logic                  s_awvalid,
   input  logic                  s_awready,
   output logic [ADDR_WIDTH-1:0] s_awaddr,
   output logic [7:0]            s_awlen,
   output logic                  s_wvalid,
   input  logic                  s_wready,
   output logic [DATA_WIDTH-1:0] s_wdata,
   output logic                  s_wlast,
   input  logic                  s_bvalid,
   output logic                  s_bready,
   output logic                  beat_err
);

   arb_state_e state_r, state_s;
   logic       gnt_r, gnt_s;
   logic       prio_r, prio_s;
   logic       in_addr_s, in_data_s, in_resp_s;

   // State, grant and round-robin pointer registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         gnt_r   <= 1'b0;
         prio_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         gnt_r   <= gnt_s;
         prio_r  <= prio_s;
      end
   end

   // Next-state, grant capture and pointer update
   always_comb begin
      state_s = state_r;
      gnt_s   = gnt_r;
      prio_s  = prio_r;
      case (state_r)
         ST_IDLE: begin
            if (init_end && (m0_awvalid || m1_awvalid)) begin
               gnt_s   = rr_pick(m0_awvalid, m1_awvalid, prio_r);
               state_s = ST_ADDR;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ADDR: begin
            if (s_awvalid && s_awready) begin
               state_s = ST_DATA;
            end else begin
               state_s = ST_ADDR;
            end
         end
         ST_DATA: begin
            if (s_wvalid && s_wready && s_wlast) begin
               state_s = ST_RESP;
            end else begin
               state_s = ST_DATA;
            end
         end
         ST_RESP: begin
            if (s_bvalid && s_bready) begin
               prio_s  = ~gnt_r;
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RESP;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Zero-latency channel routing; everything is closed while rst is held
   always_comb begin
      in_addr_s  = !rst && (state_r == ST_ADDR);
      in_data_s  = !rst && (state_r == ST_DATA);
      in_resp_s  = !rst && (state_r == ST_RESP);

      s_awvalid  = in_addr_s && (gnt_r ? m1_awvalid : m0_awvalid);
      s_awaddr   = gnt_r ? m1_awaddr : m0_awaddr;
      s_awlen    = gnt_r ? m1_awlen  : m0_awlen;
      m0_awready = in_addr_s && !gnt_r && s_awready;
      m1_awready = in_addr_s &&  gnt_r && s_awready;

      s_wvalid   = in_data_s && (gnt_r ? m1_wvalid : m0_wvalid);
      s_wdata    = gnt_r ? m1_wdata : m0_wdata;
      s_wlast    = gnt_r ? m1_wlast : m0_wlast;
      m0_wready  = in_data_s && !gnt_r && s_wready;
      m1_wready  = in_data_s &&  gnt_r && s_wready;

      s_bready   = in_resp_s && (gnt_r ? m1_bready : m0_bready);
      m0_bvalid  = in_resp_s && !gnt_r && s_bvalid;
      m1_bvalid  = in_resp_s &&  gnt_r && s_bvalid;
   end

`ifdef DDR2_ARB_BEAT_CHK_EN
   logic [7:0] beat_cnt_r;
   logic [7:0] awlen_r;
   logic       beat_err_r;

   // Beat counting against the accepted awlen; error is sticky until rst
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt_r <= 8'd0;
         awlen_r    <= 8'd0;
         beat_err_r <= 1'b0;
      end else if (s_awvalid && s_awready) begin
         beat_cnt_r <= 8'd0;
         awlen_r    <= s_awlen;
      end else if (s_wvalid && s_wready) begin
         beat_cnt_r <= beat_cnt_r + 8'd1;
         if (s_wlast && (({1'b0, beat_cnt_r} + 9'd1) != ({1'b0, awlen_r} + 9'd1))) begin
            beat_err_r <= 1'b1;
         end else begin
            beat_err_r <= beat_err_r;
         end
      end else begin
         beat_cnt_r <= beat_cnt_r;
      end
   end

   assign beat_err = beat_err_r;
`else
   assign beat_err = 1'b0;
`endif

endmodule

// File: tb/tb_ddr2_wr_arb.sv
// Scoreboard bench for ddr2_wr_arb: table of arbitration scenarios plus
// hand-written reset, init_end and burst-length sequences.
module tb_ddr2_wr_arb;

   localparam int AW  = 26;
   localparam int DW  = 32;
   localparam int TMO = 2000;

   logic clk, rst, init_end;
   logic m0_awvalid, m0_awready, m0_wvalid, m0_wready, m0_wlast, m0_bvalid, m0_bready;
   logic m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_wlast, m1_bvalid, m1_bready;
   logic [AW-1:0] m0_awaddr, m1_awaddr, s_awaddr;
   logic [7:0]    m0_awlen, m1_awlen, s_awlen;
   logic [DW-1:0] m0_wdata, m1_wdata, s_wdata;
   logic s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready, beat_err;

   ddr2_wr_arb dut (
      .clk(clk), .rst(rst), .init_end(init_end),
      .m0_awvalid(m0_awvalid), .m0_awready(m0_awready), .m0_awaddr(m0_awaddr), .m0_awlen(m0_awlen),
      .m0_wvalid(m0_wvalid), .m0_wready(m0_wready), .m0_wdata(m0_wdata), .m0_wlast(m0_wlast),
      .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
      .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr), .m1_awlen(m1_awlen),
      .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wlast(m1_wlast),
      .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wlast(s_wlast),
      .s_bvalid(s_bvalid), .s_bready(s_bready), .beat_err(beat_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] req;
      logic [7:0] len0;
      logic [7:0] len1;
      logic       rnd;
      logic       first;
   } vec_t;

   typedef struct {
      logic          mst;
      logic [AW-1:0] addr;
      logic [7:0]    len;
   } aw_exp_t;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } w_exp_t;

   vec_t    vecs[7];
   aw_exp_t aw_q[$];
   w_exp_t  w_q[$];

   int   tests = 0;
   int   fails = 0;
   int   iso_err = 0;
   int   seen;
   logic slave_en = 1'b0;
   logic rnd_rdy = 1'b0;
   logic b_pend = 1'b0;
   logic cur_mst = 1'b0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic void push_burst(input logic m, input logic [AW-1:0] addr, input logic [7:0] len,
                                      input logic [DW-1:0] dbase, input int last_beat);
      aw_exp_t a;
      w_exp_t  w;
      a.mst = m; a.addr = addr; a.len = len;
      aw_q.push_back(a);
      for (int b = 0; b <= last_beat; b++) begin
         w.data = dbase + DW'(b);
         w.last = (b == last_beat);
         w_q.push_back(w);
      end
   endfunction

   function automatic logic [AW-1:0] vaddr(input logic m, input int vi);
      return AW'(vi * 16 + 1) + (m ? AW'(26'h200000) : AW'(26'h0));
   endfunction

   function automatic logic [DW-1:0] vdata(input logic m, input int vi);
      return {(m ? 8'hB1 : 8'hA0), 8'(vi), 16'h0000};
   endfunction

   task automatic drive_aw(input logic m, input logic v, input logic [AW-1:0] a, input logic [7:0] l);
      if (m) begin m1_awvalid = v; m1_awaddr = a; m1_awlen = l; end
      else   begin m0_awvalid = v; m0_awaddr = a; m0_awlen = l; end
   endtask

   task automatic drive_w(input logic m, input logic v, input logic [DW-1:0] d, input logic l);
      if (m) begin m1_wvalid = v; m1_wdata = d; m1_wlast = l; end
      else   begin m0_wvalid = v; m0_wdata = d; m0_wlast = l; end
   endtask

   task automatic master_burst(input logic m, input logic [AW-1:0] addr, input logic [7:0] len,
                               input logic [DW-1:0] dbase, input int last_beat);
      int n;
      @(negedge clk);
      drive_aw(m, 1'b1, addr, len);
      n = 0; #2;
      while (!(m ? m1_awready : m0_awready) && n < TMO) begin @(negedge clk); #2; n++; end
      check("aw_wait_ok", 64'(n < TMO), 64'd1);
      if (n >= TMO) begin drive_aw(m, 1'b0, addr, len); return; end
      @(negedge clk);
      drive_aw(m, 1'b0, addr, len);
      for (int b = 0; b <= last_beat; b++) begin
         drive_w(m, 1'b1, dbase + DW'(b), b == last_beat);
         n = 0; #2;
         while (!(m ? m1_wready : m0_wready) && n < TMO) begin @(negedge clk); #2; n++; end
         check("w_wait_ok", 64'(n < TMO), 64'd1);
         if (n >= TMO) begin drive_w(m, 1'b0, '0, 1'b0); return; end
         @(negedge clk);
      end
      drive_w(m, 1'b0, '0, 1'b0);
      if (m) m1_bready = 1'b1; else m0_bready = 1'b1;
      n = 0; #2;
      while (!(m ? m1_bvalid : m0_bvalid) && n < TMO) begin @(negedge clk); #2; n++; end
      check("b_wait_ok", 64'(n < TMO), 64'd1);
      @(negedge clk);
      if (m) m1_bready = 1'b0; else m0_bready = 1'b0;
   endtask

   // Slave model and scoreboard monitor, sampled 2 units after the falling edge
   initial begin
      aw_exp_t ea;
      w_exp_t  ew;
      forever begin
         @(negedge clk);
         if (slave_en) begin
            s_awready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            s_wready  = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            s_bvalid  = b_pend;
         end
         #2;
         if (rst) begin
            b_pend = 1'b0;
         end else if (slave_en) begin
            if (s_awvalid && s_awready) begin
               check("aw_expected", 64'(aw_q.size() > 0), 64'd1);
               if (aw_q.size() > 0) begin
                  ea = aw_q.pop_front();
                  cur_mst = ea.mst;
                  check("aw_master", 64'(m1_awready), 64'(ea.mst));
                  check("aw_addr", 64'(s_awaddr), 64'(ea.addr));
                  check("aw_len", 64'(s_awlen), 64'(ea.len));
               end
            end
            if (s_wvalid && s_wready) begin
               check("w_expected", 64'(w_q.size() > 0), 64'd1);
               if (w_q.size() > 0) begin
                  ew = w_q.pop_front();
                  check("w_data", 64'(s_wdata), 64'(ew.data));
                  check("w_last", 64'(s_wlast), 64'(ew.last));
               end
               if (s_wlast) b_pend = 1'b1;
            end
            if (s_bvalid && s_bready) b_pend = 1'b0;
            if ((m0_awready && m1_awready) || (m0_wready && m1_wready) || (m0_bvalid && m1_bvalid)) iso_err++;
            if (32'(s_awvalid) + 32'(s_wvalid) + 32'(s_bready) > 32'd1) iso_err++;
            if (!cur_mst && (m1_wready || m1_bvalid)) iso_err++;
            if (cur_mst && (m0_wready || m0_bvalid)) iso_err++;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: finished=0 expected=1");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{2'b11, 8'd7, 8'd7, 1'b0, 1'b0};
      vecs[1] = '{2'b11, 8'd7, 8'd7, 1'b0, 1'b0};
      vecs[2] = '{2'b10, 8'd0, 8'd3, 1'b0, 1'b1};
      vecs[3] = '{2'b10, 8'd0, 8'd0, 1'b0, 1'b1};
      vecs[4] = '{2'b01, 8'd7, 8'd0, 1'b1, 1'b0};
      vecs[5] = '{2'b11, 8'd2, 8'd5, 1'b0, 1'b1};
      vecs[6] = '{2'b11, 8'd0, 8'd0, 1'b1, 1'b1};

      rst = 1'b1; init_end = 1'b0;
      m0_awvalid = 1'b1; m0_awaddr = '0; m0_awlen = '0; m0_wvalid = 1'b0; m0_wdata = '0; m0_wlast = 1'b0; m0_bready = 1'b1;
      m1_awvalid = 1'b0; m1_awaddr = '0; m1_awlen = '0; m1_wvalid = 1'b0; m1_wdata = '0; m1_wlast = 1'b0; m1_bready = 1'b0;
      s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1;

      // Reset state with readies and valids pushed high
      repeat (3) @(negedge clk);
      #2;
      check("rst_s_awvalid", 64'(s_awvalid), 64'd0);
      check("rst_s_wvalid", 64'(s_wvalid), 64'd0);
      check("rst_s_bready", 64'(s_bready), 64'd0);
      check("rst_m_ready", 64'({m0_awready, m1_awready, m0_wready, m1_wready}), 64'd0);
      check("rst_m_bvalid", 64'({m0_bvalid, m1_bvalid}), 64'd0);
      check("rst_beat_err", 64'(beat_err), 64'd0);

      // No grant while init_end is low, then one-cycle grant latency
      @(negedge clk);
      rst = 1'b0; s_awready = 1'b0; s_bvalid = 1'b0; m0_bready = 1'b0;
      m0_awaddr = 26'h0ABCDE; m0_awlen = 8'd3;
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); #2;
         if (s_awvalid) seen++;
      end
      check("no_grant_before_init", 64'(seen), 64'd0);
      @(negedge clk);
      init_end = 1'b1; #2;
      check("grant_not_same_cycle", 64'(s_awvalid), 64'd0);
      @(negedge clk); #2;
      check("grant_s_awvalid", 64'(s_awvalid), 64'd1);
      check("grant_s_awaddr", 64'(s_awaddr), 64'(26'h0ABCDE));
      check("grant_s_awlen", 64'(s_awlen), 64'd3);
      s_awready = 1'b1; #1;
      check("awready_route", 64'({m1_awready, m0_awready}), 64'd1);
      @(negedge clk);
      m0_awvalid = 1'b0; m0_wvalid = 1'b1; m0_wdata = 32'hD00D0000; init_end = 1'b0; #2;
      check("data_s_wvalid", 64'(s_wvalid), 64'd1);
      check("data_s_wdata", 64'(s_wdata), 64'(32'hD00D0000));
      check("wready_route", 64'({m1_wready, m0_wready}), 64'd1);
      check("data_no_awvalid", 64'(s_awvalid), 64'd0);
      @(negedge clk);
      m0_wdata = 32'hD00D0001; #2;
      check("init_drop_no_abort", 64'(s_wvalid), 64'd1);

      // Reset in the middle of the data phase
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk); #2;
      check("midrst_outputs", 64'({s_awvalid, s_wvalid, s_bready, m0_awready, m1_awready,
                                   m0_wready, m1_wready, m0_bvalid, m1_bvalid, beat_err}), 64'd0);
      @(negedge clk);
      rst = 1'b0; #2;
      check("post_rst_idle", 64'(s_wvalid), 64'd0);
      m0_wvalid = 1'b0; init_end = 1'b1;
      drive_aw(1'b0, 1'b1, 26'h0000111, 8'd0);
      drive_aw(1'b1, 1'b1, 26'h0000222, 8'd0);
      @(negedge clk); #2;
      check("rst_prio_m0_addr", 64'(s_awaddr), 64'(26'h0000111));
      check("rst_prio_m0_valid", 64'(s_awvalid), 64'd1);

      @(negedge clk);
      rst = 1'b1; s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0;
      drive_aw(1'b0, 1'b0, '0, '0);
      drive_aw(1'b1, 1'b0, '0, '0);
      slave_en = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Table of arbitration scenarios; pointer carries over between rows
      for (int vi = 0; vi < 7; vi++) begin
         rnd_rdy = vecs[vi].rnd;
         iso_err = 0;
         if (vecs[vi].req == 2'b11) begin
            push_burst(vecs[vi].first, vaddr(vecs[vi].first, vi), vecs[vi].first ? vecs[vi].len1 : vecs[vi].len0,
                       vdata(vecs[vi].first, vi), vecs[vi].first ? int'(vecs[vi].len1) : int'(vecs[vi].len0));
            push_burst(!vecs[vi].first, vaddr(!vecs[vi].first, vi), vecs[vi].first ? vecs[vi].len0 : vecs[vi].len1,
                       vdata(!vecs[vi].first, vi), vecs[vi].first ? int'(vecs[vi].len0) : int'(vecs[vi].len1));
         end else if (vecs[vi].req[0]) begin
            push_burst(1'b0, vaddr(1'b0, vi), vecs[vi].len0, vdata(1'b0, vi), int'(vecs[vi].len0));
         end else begin
            push_burst(1'b1, vaddr(1'b1, vi), vecs[vi].len1, vdata(1'b1, vi), int'(vecs[vi].len1));
         end
         fork
            if (vecs[vi].req[0]) master_burst(1'b0, vaddr(1'b0, vi), vecs[vi].len0, vdata(1'b0, vi), int'(vecs[vi].len0));
            if (vecs[vi].req[1]) master_burst(1'b1, vaddr(1'b1, vi), vecs[vi].len1, vdata(1'b1, vi), int'(vecs[vi].len1));
         join
         repeat (3) @(negedge clk);
         check("vec_isolation", 64'(iso_err), 64'd0);
         check("vec_drained", 64'(aw_q.size() + w_q.size()), 64'd0);
      end

      // Burst length mismatch: awlen=7 but wlast on the seventh beat
      rnd_rdy = 1'b0;
      #2;
      check("beat_err_clean", 64'(beat_err), 64'd0);
      push_burst(1'b0, 26'h0003000, 8'd7, 32'hE0000000, 6);
      master_burst(1'b0, 26'h0003000, 8'd7, 32'hE0000000, 6);
      repeat (2) @(negedge clk); #2;
`ifdef DDR2_ARB_BEAT_CHK_EN
      check("beat_err_set", 64'(beat_err), 64'd1);
`else
      check("beat_err_tied", 64'(beat_err), 64'd0);
`endif
      push_burst(1'b1, 26'h0003100, 8'd1, 32'hE1000000, 1);
      master_burst(1'b1, 26'h0003100, 8'd1, 32'hE1000000, 1);
      repeat (2) @(negedge clk); #2;
`ifdef DDR2_ARB_BEAT_CHK_EN
      check("beat_err_sticky", 64'(beat_err), 64'd1);
`else
      check("beat_err_still_tied", 64'(beat_err), 64'd0);
`endif
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk); #2;
      check("beat_err_rst", 64'(beat_err), 64'd0);
      rst = 1'b0;
      check("final_drained", 64'(aw_q.size() + w_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
